// File: rtl/nanorv32_test_monitor_if.sv
// rtl/nanorv32_test_monitor_if.sv - core observation bus seen by the end-of-test monitor
interface nanorv32_test_monitor_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  pc_valid;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] a0;
  logic                  illegal_instruction;
  logic                  mbox_wr;
  logic [DATA_WIDTH-1:0] mbox_addr;
  logic [DATA_WIDTH-1:0] mbox_wdata;

  modport master (
    output pc_valid, pc, a0, illegal_instruction, mbox_wr, mbox_addr, mbox_wdata
  );

  modport slave (
    input pc_valid, pc, a0, illegal_instruction, mbox_wr, mbox_addr, mbox_wdata
  );
endinterface

// File: rtl/nanorv32_test_monitor.sv
// rtl/nanorv32_test_monitor.sv - latches the first end-of-test event of a nanorv32 run
module nanorv32_test_monitor #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    CNT_W          = 32,
  parameter logic [DATA_WIDTH-1:0] END_PC         = 'h0000_0100,
  parameter logic [DATA_WIDTH-1:0] PASS_VALUE     = 'hCAFF_E000,
  parameter logic [DATA_WIDTH-1:0] FAIL_VALUE     = 'h0DEA_D000,
  parameter logic [DATA_WIDTH-1:0] MAILBOX_ADDR   = 'hFFFF_FFF0,
  parameter int unsigned           TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  nanorv32_test_monitor_if.slave core,
  output logic                  status_valid,
  output logic                  done_pulse,
  output logic [2:0]            status_code,
  output logic [DATA_WIDTH-1:0] status_value,
  output logic [CNT_W-1:0]      cycle_count,
  output logic [CNT_W-1:0]      retired_count
);

  localparam logic [2:0] CODE_NONE    = 3'd0;
  localparam logic [2:0] CODE_PASS    = 3'd1;
  localparam logic [2:0] CODE_FAIL    = 3'd2;
  localparam logic [2:0] CODE_UNKNOWN = 3'd3;
  localparam logic [2:0] CODE_ILLEGAL = 3'd4;
  localparam logic [2:0] CODE_TIMEOUT = 3'd5;

  localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
  // Wraps harmlessly when the timeout is disabled; TIMEOUT_EN gates it.
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);
  localparam logic             TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            code_q, code_d;
  logic [DATA_WIDTH-1:0] value_q, value_d;
  logic [CNT_W-1:0]      cycle_q, cycle_d;
  logic [CNT_W-1:0]      retired_q, retired_d;
  logic [DATA_WIDTH-1:0] last_pc_q, last_pc_d;
  logic                  pulse_q, pulse_d;

  logic ev_illegal, ev_endpc, ev_mbox, ev_timeout, ev_any;

  function automatic logic [2:0] classify(input logic [DATA_WIDTH-1:0] v);
    if (v == PASS_VALUE) return CODE_PASS;
    if (v == FAIL_VALUE) return CODE_FAIL;
    return CODE_UNKNOWN;
  endfunction

  assign ev_illegal = core.illegal_instruction;
  assign ev_endpc   = core.pc_valid && (core.pc == END_PC);
  assign ev_mbox    = core.mbox_wr && (core.mbox_addr == MAILBOX_ADDR);
  assign ev_timeout = TIMEOUT_EN && (cycle_q == TIMEOUT_LAST);
  assign ev_any     = ev_illegal || ev_endpc || ev_mbox || ev_timeout;

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    value_d   = value_q;
    cycle_d   = cycle_q;
    retired_d = retired_q;
    last_pc_d = last_pc_q;
    pulse_d   = 1'b0;
    if (clr) begin
      state_d   = ST_RUN;
      code_d    = CODE_NONE;
      value_d   = '0;
      cycle_d   = '0;
      retired_d = '0;
      last_pc_d = '0;
    end else if (state_q == ST_RUN) begin
      cycle_d = cycle_q + CNT_ONE;
      if (core.pc_valid) begin
        retired_d = retired_q + CNT_ONE;
        last_pc_d = core.pc;
      end
      // A pc retiring in the timeout cycle itself counts as the last one seen.
      if (ev_illegal) begin
        code_d  = CODE_ILLEGAL;
        value_d = core.pc;
      end else if (ev_endpc) begin
        code_d  = classify(core.a0);
        value_d = core.a0;
      end else if (ev_mbox) begin
        code_d  = classify(core.mbox_wdata);
        value_d = core.mbox_wdata;
      end else if (ev_timeout) begin
        code_d  = CODE_TIMEOUT;
        value_d = last_pc_d;
      end
      if (ev_any) begin
        state_d = ST_DONE;
        pulse_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      code_q    <= CODE_NONE;
      value_q   <= '0;
      cycle_q   <= '0;
      retired_q <= '0;
      last_pc_q <= '0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      value_q   <= value_d;
      cycle_q   <= cycle_d;
      retired_q <= retired_d;
      last_pc_q <= last_pc_d;
      pulse_q   <= pulse_d;
    end
  end

  assign status_valid  = (state_q == ST_DONE);
  assign done_pulse    = pulse_q;
  assign status_code   = code_q;
  assign status_value  = value_q;
  assign cycle_count   = cycle_q;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_nanorv32_test_monitor.sv
// tb/tb_nanorv32_test_monitor.sv - scoreboard bench for the nanorv32 end-of-test monitor
module tb_nanorv32_test_monitor;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        status_valid;
  logic        done_pulse;
  logic [2:0]  status_code;
  logic [31:0] status_value;
  logic [31:0] cycle_count;
  logic [31:0] retired_count;

  int vectors;
  int miscompares;

  typedef struct {
    logic [2:0]  code;
    logic [31:0] value;
  } exp_t;

  exp_t sb_q[$];

  nanorv32_test_monitor_if #(.DATA_WIDTH(32)) core_if ();

  nanorv32_test_monitor #(
    .DATA_WIDTH    (32),
    .CNT_W         (32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .core         (core_if.slave),
    .status_valid (status_valid),
    .done_pulse   (done_pulse),
    .status_code  (status_code),
    .status_value (status_value),
    .cycle_count  (cycle_count),
    .retired_count(retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    core_if.pc_valid            = 1'b0;
    core_if.pc                  = 32'h0;
    core_if.a0                  = 32'h0;
    core_if.illegal_instruction = 1'b0;
    core_if.mbox_wr             = 1'b0;
    core_if.mbox_addr           = 32'h0;
    core_if.mbox_wdata          = 32'h0;
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // Crosses clock edges until done_pulse is seen; inputs are dropped after the first edge.
  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (i == 0) idle();
      if (done_pulse === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clr   = 1'b0;
    idle();
    @(negedge clk);
    vectors++; if (status_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%0b exp=0", status_valid); end
    vectors++; if (done_pulse !== 1'b0) begin miscompares++; $display("FAIL reset_pulse got=%0b exp=0", done_pulse); end
    vectors++; if (status_code !== 3'd0) begin miscompares++; $display("FAIL reset_code got=%0d exp=0", status_code); end
    vectors++; if (status_value !== 32'h0) begin miscompares++; $display("FAIL reset_value got=%h exp=0", status_value); end
    vectors++; if (cycle_count !== 32'h0) begin miscompares++; $display("FAIL reset_cycles got=%0d exp=0", cycle_count); end
    vectors++; if (retired_count !== 32'h0) begin miscompares++; $display("FAIL reset_retired got=%0d exp=0", retired_count); end
    rst_n = 1'b1;
  endtask

  task automatic test_endpc();
    logic [31:0] a0_tab[3];
    logic [2:0]  code_tab[3];
    exp_t        e;
    bit          seen;
    a0_tab   = '{32'hCAFF_E000, 32'h0DEA_D000, 32'h1234_5678};
    code_tab = '{3'd1, 3'd2, 3'd3};
    for (int k = 0; k < 3; k++) begin
      do_clr();
      sb_q.push_back('{code: code_tab[k], value: a0_tab[k]});
      core_if.pc_valid = 1'b1;
      core_if.pc       = 32'h100;
      core_if.a0       = a0_tab[k];
      wait_done(4, seen);
      vectors++; if (!seen) begin miscompares++; $display("FAIL endpc_done[%0d] got=0 exp=1", k); end
      e = sb_q.pop_front();
      vectors++; if (status_code !== e.code) begin miscompares++; $display("FAIL endpc_code[%0d] got=%0d exp=%0d", k, status_code, e.code); end
      vectors++; if (status_value !== e.value) begin miscompares++; $display("FAIL endpc_value[%0d] got=%h exp=%h", k, status_value, e.value); end
      vectors++; if (cycle_count !== 32'd1) begin miscompares++; $display("FAIL endpc_cycles[%0d] got=%0d exp=1", k, cycle_count); end
      vectors++; if (retired_count !== 32'd1) begin miscompares++; $display("FAIL endpc_retired[%0d] got=%0d exp=1", k, retired_count); end
      @(negedge clk);
      vectors++; if (done_pulse !== 1'b0) begin miscompares++; $display("FAIL endpc_pulse_width[%0d] got=%0b exp=0", k, done_pulse); end
      vectors++; if (status_valid !== 1'b1) begin miscompares++; $display("FAIL endpc_sticky[%0d] got=%0b exp=1", k, status_valid); end
    end
    // Further events in DONE must not disturb the latched result.
    core_if.pc_valid            = 1'b1;
    core_if.pc                  = 32'h100;
    core_if.a0                  = 32'hCAFF_E000;
    core_if.illegal_instruction = 1'b1;
    core_if.mbox_wr             = 1'b1;
    core_if.mbox_addr           = 32'hFFFF_FFF0;
    core_if.mbox_wdata          = 32'h0DEA_D000;
    repeat (3) @(negedge clk);
    idle();
    vectors++; if (status_code !== 3'd3) begin miscompares++; $display("FAIL frozen_code got=%0d exp=3", status_code); end
    vectors++; if (status_value !== 32'h1234_5678) begin miscompares++; $display("FAIL frozen_value got=%h exp=12345678", status_value); end
    vectors++; if (cycle_count !== 32'd1) begin miscompares++; $display("FAIL frozen_cycles got=%0d exp=1", cycle_count); end
    vectors++; if (retired_count !== 32'd1) begin miscompares++; $display("FAIL frozen_retired got=%0d exp=1", retired_count); end
    vectors++; if (done_pulse !== 1'b0) begin miscompares++; $display("FAIL frozen_pulse got=%0b exp=0", done_pulse); end
  endtask

  task automatic test_priority();
    exp_t e;
    bit   seen;
    do_clr();
    sb_q.push_back('{code: 3'd4, value: 32'h100});
    core_if.illegal_instruction = 1'b1;
    core_if.pc_valid            = 1'b1;
    core_if.pc                  = 32'h100;
    core_if.a0                  = 32'hCAFF_E000;
    core_if.mbox_wr             = 1'b1;
    core_if.mbox_addr           = 32'hFFFF_FFF0;
    core_if.mbox_wdata          = 32'hCAFF_E000;
    wait_done(4, seen);
    vectors++; if (!seen) begin miscompares++; $display("FAIL prio_done got=0 exp=1"); end
    e = sb_q.pop_front();
    vectors++; if (status_code !== e.code) begin miscompares++; $display("FAIL prio_code got=%0d exp=%0d", status_code, e.code); end
    vectors++; if (status_value !== e.value) begin miscompares++; $display("FAIL prio_value got=%h exp=%h", status_value, e.value); end
  endtask

  task automatic test_timeout();
    exp_t        e;
    bit          seen;
    logic [31:0] last_pc;
    do_clr();
    last_pc = 32'h0;
    for (int i = 0; i < 15; i++) begin
      core_if.pc_valid = (i < 10);
      core_if.pc       = 32'h200 + 32'(4 * i);
      if (i < 10) last_pc = core_if.pc;
      @(negedge clk);
    end
    idle();
    vectors++; if (status_valid !== 1'b0) begin miscompares++; $display("FAIL timeout_early got=%0b exp=0", status_valid); end
    sb_q.push_back('{code: 3'd5, value: last_pc});
    wait_done(3, seen);
    vectors++; if (!seen) begin miscompares++; $display("FAIL timeout_done got=0 exp=1"); end
    e = sb_q.pop_front();
    vectors++; if (status_code !== e.code) begin miscompares++; $display("FAIL timeout_code got=%0d exp=%0d", status_code, e.code); end
    vectors++; if (status_value !== e.value) begin miscompares++; $display("FAIL timeout_value got=%h exp=%h", status_value, e.value); end
    vectors++; if (cycle_count !== 32'd16) begin miscompares++; $display("FAIL timeout_cycles got=%0d exp=16", cycle_count); end
    vectors++; if (retired_count !== 32'd10) begin miscompares++; $display("FAIL timeout_retired got=%0d exp=10", retired_count); end
  endtask

  task automatic test_mailbox();
    exp_t e;
    bit   seen;
    do_clr();
    core_if.mbox_wr    = 1'b1;
    core_if.mbox_addr  = 32'hFFFF_FFF4;
    core_if.mbox_wdata = 32'hCAFF_E000;
    @(negedge clk);
    idle();
    vectors++; if (status_valid !== 1'b0) begin miscompares++; $display("FAIL mbox_miss_valid got=%0b exp=0", status_valid); end
    vectors++; if (done_pulse !== 1'b0) begin miscompares++; $display("FAIL mbox_miss_pulse got=%0b exp=0", done_pulse); end
    sb_q.push_back('{code: 3'd1, value: 32'hCAFF_E000});
    core_if.mbox_wr    = 1'b1;
    core_if.mbox_addr  = 32'hFFFF_FFF0;
    core_if.mbox_wdata = 32'hCAFF_E000;
    wait_done(4, seen);
    vectors++; if (!seen) begin miscompares++; $display("FAIL mbox_done got=0 exp=1"); end
    e = sb_q.pop_front();
    vectors++; if (status_code !== e.code) begin miscompares++; $display("FAIL mbox_code got=%0d exp=%0d", status_code, e.code); end
    vectors++; if (status_value !== e.value) begin miscompares++; $display("FAIL mbox_value got=%h exp=%h", status_value, e.value); end
    vectors++; if (cycle_count !== 32'd2) begin miscompares++; $display("FAIL mbox_cycles got=%0d exp=2", cycle_count); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #3;
    vectors++; if (status_valid !== 1'b0) begin miscompares++; $display("FAIL arst_valid got=%0b exp=0", status_valid); end
    vectors++; if (status_code !== 3'd0) begin miscompares++; $display("FAIL arst_code got=%0d exp=0", status_code); end
    vectors++; if (status_value !== 32'h0) begin miscompares++; $display("FAIL arst_value got=%h exp=0", status_value); end
    vectors++; if (cycle_count !== 32'h0) begin miscompares++; $display("FAIL arst_cycles got=%0d exp=0", cycle_count); end
    vectors++; if (retired_count !== 32'h0) begin miscompares++; $display("FAIL arst_retired got=%0d exp=0", retired_count); end
    vectors++; if (done_pulse !== 1'b0) begin miscompares++; $display("FAIL arst_pulse got=%0b exp=0", done_pulse); end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (cycle_count !== 32'd1) begin miscompares++; $display("FAIL arst_restart got=%0d exp=1", cycle_count); end
  endtask

  task automatic test_clr_in_done();
    bit seen;
    do_clr();
    core_if.pc_valid = 1'b1;
    core_if.pc       = 32'h100;
    core_if.a0       = 32'hCAFF_E000;
    wait_done(4, seen);
    vectors++; if (!seen || status_valid !== 1'b1) begin miscompares++; $display("FAIL clr_setup got=%0b exp=1", status_valid); end
    // clr and an illegal-instruction event together: the event must be discarded.
    clr                         = 1'b1;
    core_if.illegal_instruction = 1'b1;
    core_if.pc_valid            = 1'b1;
    core_if.pc                  = 32'h100;
    @(negedge clk);
    clr = 1'b0;
    idle();
    vectors++; if (status_valid !== 1'b0) begin miscompares++; $display("FAIL clr_valid got=%0b exp=0", status_valid); end
    vectors++; if (done_pulse !== 1'b0) begin miscompares++; $display("FAIL clr_pulse got=%0b exp=0", done_pulse); end
    vectors++; if (status_code !== 3'd0) begin miscompares++; $display("FAIL clr_code got=%0d exp=0", status_code); end
    vectors++; if (status_value !== 32'h0) begin miscompares++; $display("FAIL clr_value got=%h exp=0", status_value); end
    vectors++; if (cycle_count !== 32'h0) begin miscompares++; $display("FAIL clr_cycles got=%0d exp=0", cycle_count); end
    vectors++; if (retired_count !== 32'h0) begin miscompares++; $display("FAIL clr_retired got=%0d exp=0", retired_count); end
    @(negedge clk);
    vectors++; if (cycle_count !== 32'd1) begin miscompares++; $display("FAIL clr_restart got=%0d exp=1", cycle_count); end
    vectors++; if (status_valid !== 1'b0) begin miscompares++; $display("FAIL clr_run got=%0b exp=0", status_valid); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_endpc();
    test_priority();
    test_timeout();
    test_mailbox();
    test_async_reset();
    test_clr_in_done();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nanorv32_test_monitor.md
# nanorv32_test_monitor

Synthesizable end-of-test monitor for the nanorv32 core, instantiated beside the CPU in simulation and FPGA builds. It observes the executing PC, register a0, the illegal-instruction flag and a memory-mapped mailbox write port. It also counts cycles and retired instructions. The first terminating event is latched as a sticky status code and value that a testbench or host can read.

## Interface
Parameters:
- DATA_WIDTH, 32, width of pc, a0 and mailbox buses
- CNT_W, 32, width of cycle and retired counters
- END_PC, 32'h0000_0100, PC whose execution ends the test
- PASS_VALUE, 32'hCAFF_E000, a0/mailbox value meaning pass
- FAIL_VALUE, 32'h0DEA_D000, a0/mailbox value meaning fail
- MAILBOX_ADDR, 32'hFFFF_FFF0, store address acting as the test mailbox
- TIMEOUT_CYCLES, 1000000, cycles in RUN before timeout; 0 disables timeout; must be < 2^CNT_W

Ports:
- clk, in, 1, core clock
- rst_n, in, 1, asynchronous active-low reset
- clr, in, 1, synchronous clear; returns the block to RUN with counters zeroed
- pc_valid, in, 1, pc holds an executing instruction this cycle
- pc, in, DATA_WIDTH, executing PC
- a0, in, DATA_WIDTH, current value of register x10
- illegal_instruction, in, 1, core flagged an illegal instruction this cycle
- mbox_wr, in, 1, data store strobe
- mbox_addr, in, DATA_WIDTH, store address
- mbox_wdata, in, DATA_WIDTH, store data
- status_valid, out, 1, sticky; a terminating event has been latched
- done_pulse, out, 1, high for exactly one cycle when status_valid rises
- status_code, out, 3, 0 NONE, 1 PASS, 2 FAIL, 3 UNKNOWN, 4 ILLEGAL, 5 TIMEOUT
- status_value, out, DATA_WIDTH, data associated with status_code
- cycle_count, out, CNT_W, cycles spent in RUN
- retired_count, out, CNT_W, pc_valid cycles counted in RUN

## Operation
- States: RUN (entered on reset release) and DONE (sticky). There is no other state.
- Events evaluated in RUN each cycle:
  - ILLEGAL: illegal_instruction=1.
  - ENDPC: pc_valid=1 and pc==END_PC.
  - MBOX: mbox_wr=1 and mbox_addr==MAILBOX_ADDR.
  - TIMEOUT: TIMEOUT_CYCLES!=0 and cycle_count==TIMEOUT_CYCLES-1.
- Priority when several events occur in the same cycle: ILLEGAL > ENDPC > MBOX > TIMEOUT. Only the highest-priority event is latched.
- Code and value per event:
  - ILLEGAL: code 4, value = pc.
  - ENDPC: value = a0. Code 1 if a0==PASS_VALUE, 2 if a0==FAIL_VALUE, otherwise 3.
  - MBOX: value = mbox_wdata. Code is classified against PASS_VALUE/FAIL_VALUE exactly as for ENDPC.
  - TIMEOUT: code 5, value = last pc seen with pc_valid=1 (0 if none).
- Counters in RUN:
  - cycle_count increments every cycle, including the event cycle.
  - retired_count increments on pc_valid=1 and wraps modulo 2^CNT_W.
- DONE:
  - All inputs except clr are ignored.
  - Counters, code and value are frozen.
- clr: next cycle the block is in RUN with counters=0, status_valid=0, code=0, value=0. clr has priority over any event in the same cycle.

## Timing
- Reset values: status_valid=0, done_pulse=0, status_code=0, status_value=0, cycle_count=0, retired_count=0, last pc=0, state RUN.
- Latency: an event sampled at edge N gives status_valid=1, code and value valid after edge N (one-cycle latency). done_pulse is high for that cycle only.
- Timeout: after the edge at which the event fires, cycle_count==TIMEOUT_CYCLES.
- Equality compares use the full DATA_WIDTH and are unsigned. X/Z inputs are not checked.
- Reset asserted mid-test clears all state immediately and asynchronously. On release the block restarts in RUN.
- An event in the same cycle as clr is discarded.

## Test plan
- Reset, then ENDPC: pc_valid=1, pc=0x100, a0=0xCAFFE000 at edge N -> after edge N status_valid=1, code=1, value=0xCAFFE000, done_pulse high one cycle.
- ENDPC with a0=0x0DEAD000 -> code 2. Repeat with a0=0x12345678 -> code 3, value 0x12345678. Further events leave both frozen.
- Same cycle: illegal_instruction=1, pc=0x100, pc=END_PC, mailbox write of 0xCAFFE000 -> code 4, value 0x100.
- TIMEOUT_CYCLES=16, 10 pc_valid pulses, no other event -> code 5 after 16th edge, cycle_count=16, retired_count=10, value = last pc.
- Mailbox write to 0xFFFFFFF0 of 0xCAFFE000 -> code 1. A write to 0xFFFFFFF4 -> no event.
- Mid-test rst_n low for 3ns with no clock edge -> all outputs 0 asynchronously. clr in DONE -> RUN, counters restart from 0 on the next edge.
